// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one add/subtract datapath.
// Round-robin grant, operand capture at grant, registered result with carry
// and signed-overflow flags, returned through a one-cycle done pulse.
// Optional build macro: ADDSUB_SAT_EN saturates s on signed overflow.
module addsub_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         op0,
  input  logic [n-1:0] x0,
  input  logic [n-1:0] y0,
  input  logic         req1,
  input  logic         op1,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic         done0,
  output logic         done1,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  logic [n-1:0] x_q, x_d;
  logic [n-1:0] y_q, y_d;
  logic         op_q, op_d;
  logic [n-1:0] s_q, s_d;
  logic         c_out_q, c_out_d;
  logic         ovf_q, ovf_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;

  // adder_subtractor datapath: subtract is x + ~y + 1 (add_n = op_q)
  logic [n-1:0] y_eff;
  logic [n:0]   sum;
  logic [n-1:0] as_s;
  logic         as_c_out;
  logic         as_ovf;
  logic [n-1:0] s_res;
  logic         grant1;

  // Combinational add/subtract with carry-out and signed overflow
  always_comb begin
    y_eff    = op_q ? ~y_q : y_q;
    sum      = {1'b0, x_q} + {1'b0, y_eff} + {{n{1'b0}}, op_q};
    as_s     = sum[n-1:0];
    as_c_out = sum[n];
    as_ovf   = (x_q[n-1] == y_eff[n-1]) && (as_s[n-1] != x_q[n-1]);
  end

  // Result shaping: raw wrapped sum, or clamp toward the sign of x on overflow
  always_comb begin
`ifdef ADDSUB_SAT_EN
    if (as_ovf) begin
      s_res = x_q[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end else begin
      s_res = as_s;
    end
`else
    s_res = as_s;
`endif
  end

  // Next-state: grant in IDLE, capture in EXEC, pulse done and rotate in DONE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // requester 1 wins if alone, or if both ask and the pointer favours it
          grant1  = req1 && (!req0 || ptr_q);
          owner_d = grant1;
          x_d     = grant1 ? x1 : x0;
          y_d     = grant1 ? y1 : y0;
          op_d    = grant1 ? op1 : op0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = s_res;
        c_out_d = as_c_out;
        ovf_d   = as_ovf;
        done0_d = !owner_q;
        done1_d = owner_q;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = !owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter (n=4): directed cases plus randomized
// single and contended requests, checked against an integer reference model.
module tb_addsub_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [N-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [N-1:0] s;
  logic         c_out, ovf, done0, done1, busy;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  addsub_arbiter #(.n(N)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .x0(x0), .y0(y0),
    .req1(req1), .op1(op1), .x1(x1), .y1(y1),
    .s(s), .c_out(c_out), .ovf(ovf),
    .done0(done0), .done1(done1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Signed-integer reference: overflow when the true result leaves the n-bit range
  function automatic void ref_op(input bit op, input int xu, input int yu,
                                 output int es, output int ec, output int ev);
    int lim, xs, ys, r;
    lim = 1 << (N - 1);
    xs  = (xu >= lim) ? xu - 2 * lim : xu;
    ys  = (yu >= lim) ? yu - 2 * lim : yu;
    r   = op ? xs - ys : xs + ys;
    ev  = (r > lim - 1 || r < -lim) ? 1 : 0;
    ec  = op ? ((xu >= yu) ? 1 : 0) : ((xu + yu >= 2 * lim) ? 1 : 0);
    es  = ((r % (2 * lim)) + 2 * lim) % (2 * lim);
`ifdef ADDSUB_SAT_EN
    if (ev == 1) es = (r > 0) ? lim - 1 : lim;
`endif
  endfunction

  task automatic drive_port(input bit p, input bit op, input logic [N-1:0] x, input logic [N-1:0] y);
    if (p) begin op1 = op; x1 = x; y1 = y; req1 = 1'b1; end
    else   begin op0 = op; x0 = x; y0 = y; req0 = 1'b1; end
  endtask

  task automatic scramble(input bit p);
    if (p) begin op1 = 1'($urandom); x1 = N'($urandom); y1 = N'($urandom); end
    else   begin op0 = 1'($urandom); x0 = N'($urandom); y0 = N'($urandom); end
  endtask

  // Wait (bounded) for a done pulse and compare it with the model
  task automatic wait_result(input bit p, input int lat, input bit first_grant,
                             input bit op, input logic [N-1:0] x, input logic [N-1:0] y);
    int cyc, es, ec, ev;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    ref_op(op, int'(x), int'(y), es, ec, ev);
    while (cyc < 8 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && first_grant) begin
        check("busy_exec", 32'(busy), 32'd1);
        scramble(p);
      end
      if (done0 || done1) seen = 1'b1;
    end
    check("latency", cyc, lat);
    check(p ? "done1" : "done0", 32'(p ? done1 : done0), 32'd1);
    check(p ? "done0_quiet" : "done1_quiet", 32'(p ? done0 : done1), 32'd0);
    check("s", 32'(s), es);
    check("c_out", 32'(c_out), ec);
    check("ovf", 32'(ovf), ev);
    check("busy_done", 32'(busy), 32'd1);
    $display("op port=%0d op=%0d x=%0d y=%0d -> s=%0d c=%0d v=%0d lat=%0d",
             p, op, x, y, s, c_out, ovf, cyc);
    if (p) req1 = 1'b0; else req0 = 1'b0;
    ptr_m = p ? 0 : 1;
  endtask

  task automatic do_single(input bit p, input bit op, input logic [N-1:0] x, input logic [N-1:0] y);
    drive_port(p, op, x, y);
    wait_result(p, 2, 1'b1, op, x, y);
    @(posedge clk); #1;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic do_pair(input bit oa, input logic [N-1:0] xa, input logic [N-1:0] ya,
                         input bit ob, input logic [N-1:0] xb, input logic [N-1:0] yb);
    bit w;
    drive_port(1'b0, oa, xa, ya);
    drive_port(1'b1, ob, xb, yb);
    w = (ptr_m == 1);
    if (w) begin
      wait_result(1'b1, 2, 1'b1, ob, xb, yb);
      wait_result(1'b0, 3, 1'b0, oa, xa, ya);
    end else begin
      wait_result(1'b0, 2, 1'b1, oa, xa, ya);
      wait_result(1'b1, 3, 1'b0, ob, xb, yb);
    end
    @(posedge clk); #1;
    check("idle_after_pair", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ptr_m = 0;
    check("rst_s", 32'(s), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    apply_reset();

    // directed arithmetic cases
    do_single(1'b0, 1'b0, 4'd3, 4'd4);
    do_single(1'b1, 1'b1, 4'd5, 4'd3);
    do_single(1'b0, 1'b0, 4'd7, 4'd1);
    do_single(1'b0, 1'b1, 4'd8, 4'd1);

    // contended pairs right after reset
    apply_reset();
    do_pair(1'b0, 4'd1, 4'd2, 1'b1, 4'd6, 4'd9);
    do_pair(1'b1, 4'd0, 4'd0, 1'b0, 4'd15, 4'd15);

    // reset during EXEC: operation dropped, pointer back to requester 0
    do_single(1'b0, 1'b0, 4'd3, 4'd2);
    drive_port(1'b0, 1'b0, 4'd7, 4'd7);
    @(posedge clk); #1;
    check("rst_mid_busy", 32'(busy), 32'd1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done0 | done1), 32'd0);
    end
    do_pair(1'b0, 4'd2, 4'd2, 1'b1, 4'd4, 4'd1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int mode, gap;
      mode = int'($urandom_range(0, 2));
      gap  = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      if (mode == 2)
        do_pair(1'($urandom), N'($urandom), N'($urandom),
                1'($urandom), N'($urandom), N'($urandom));
      else
        do_single(mode[0], 1'($urandom), N'($urandom), N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
